// File: rtl/symlock_pkg.sv
// ============================================================================
// Module      : symlock_pkg
// Description : Shared types and constants for the symbol-lock controller:
//               FSM state enum, K28.5 comma patterns, offset width and a
//               comma-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package symlock_pkg;

  localparam int OFF_W  = 4;
  localparam int WORD_W = 10;

  // K28.5 in both running disparities
  localparam logic [WORD_W-1:0] c_K28P = 10'b0011111010;
  localparam logic [WORD_W-1:0] c_K28N = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic is_comma(input logic [WORD_W-1:0] w);
    return (w == c_K28P) || (w == c_K28N);
  endfunction

endpackage

`default_nettype wire

// File: rtl/symbol_lock_ctrl_comma_search.sv
// ============================================================================
// Module      : comma_search
// Description : Combinational priority search of a 20-bit window for a K28.5
//               comma at bit offsets 0..9; the lowest matching offset wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comma_search
  import symlock_pkg::*;
(
  input  logic [19:0]      i_win,
  output logic             o_hit,
  output logic [OFF_W-1:0] o_hit_off
);

  logic [9:0] w_match;

  genvar gk;
  generate
    for (gk = 0; gk < 10; gk++) begin : g_slice
      // offset k takes the ten bits starting k positions below the window MSB
      assign w_match[gk] = is_comma(i_win[19-gk -: 10]);
    end
  endgenerate

  // Scan from the highest offset down so the lowest matching offset is kept
  always_comb begin
    o_hit     = |w_match;
    o_hit_off = '0;
    for (int k = 9; k >= 0; k--) begin
      if (w_match[k]) begin
        o_hit_off = OFF_W'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/symbol_lock_ctrl.sv
// ============================================================================
// Module      : symbol_lock_ctrl
// Description : Word-alignment / symbol-lock controller for the 10-bit receive
//               path. Hunts for K28.5 at any of 10 bit offsets, qualifies the
//               offset over LOCK_CNT commas, then freezes it and outputs
//               aligned words, rx_valid and a comma pulse. Drops lock on
//               repeated decoder errors or misaligned commas.
//               Optional build macro SYMLOCK_RELOCK_CNT_EN adds o_relock_cnt,
//               a saturating count of LOCKED->SEARCH transitions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module symbol_lock_ctrl
  import symlock_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int GAP_MAX  = 64,
  parameter int ERR_MAX  = 4,
  parameter int CLR_WIN  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rx_en,
  input  logic [9:0]       i_data_in,
  input  logic             i_code_err,
  output logic [9:0]       o_data_out,
  output logic [OFF_W-1:0] o_align_off,
  output logic             o_rx_valid,
  output logic             o_comma_pulse,
  output logic             o_locked
`ifdef SYMLOCK_RELOCK_CNT_EN
  ,
  output logic [7:0]       o_relock_cnt
`endif
);

  localparam int OK_W  = $clog2(LOCK_CNT + 1);
  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam int ERR_W = $clog2(ERR_MAX + 1);
  localparam int CLR_W = $clog2(CLR_WIN + 1);

  localparam logic [OK_W-1:0]  c_OK_MAX  = OK_W'(LOCK_CNT);
  localparam logic [GAP_W-1:0] c_GAP_MAX = GAP_W'(GAP_MAX);
  localparam logic [ERR_W-1:0] c_ERR_MAX = ERR_W'(ERR_MAX);
  localparam logic [CLR_W-1:0] c_CLR_MAX = CLR_W'(CLR_WIN);

  state_t           r_state;
  logic [9:0]       r_prev_word;
  logic [9:0]       r_data_out;
  logic [OFF_W-1:0] r_align_off;
  logic [OFF_W-1:0] r_cand_off;
  logic             r_comma_pulse;
  logic             r_locked;
  logic [OK_W-1:0]  r_ok_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic [CLR_W-1:0] r_clean_cnt;

  logic [19:0]      w_win;
  logic             w_hit;
  logic [OFF_W-1:0] w_hit_off;
  logic [9:0]       w_slice;
  logic             w_err_evt;
  logic             w_drop;

  assign w_win = {r_prev_word, i_data_in};

  comma_search u_comma_search (
    .i_win     (w_win),
    .o_hit     (w_hit),
    .o_hit_off (w_hit_off)
  );

  // Select the ten window bits at the current alignment offset
  always_comb begin
    w_slice = '0;
    for (int k = 0; k < 10; k++) begin
      if (r_align_off == OFF_W'(k)) begin
        w_slice = w_win[19-k -: 10];
      end
    end
  end

  // A decoder error and a misaligned comma in the same word are one event
  assign w_err_evt = i_code_err | (w_hit & (w_hit_off != r_align_off));
  assign w_drop    = (r_state == ST_LOCKED) && w_err_evt &&
                     (r_err_cnt >= c_ERR_MAX - 1'b1);

  // Word history, aligned data and comma pulse, all advancing on the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_word   <= '0;
      r_data_out    <= '0;
      r_comma_pulse <= 1'b0;
    end else if (i_rx_en) begin
      r_prev_word   <= i_data_in;
      r_data_out    <= w_slice;
      r_comma_pulse <= (r_state == ST_LOCKED) && w_hit &&
                       (w_hit_off == r_align_off);
    end
  end

  // Alignment FSM with qualification, gap and error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_align_off <= '0;
      r_cand_off  <= '0;
      r_locked    <= 1'b0;
      r_ok_cnt    <= '0;
      r_gap_cnt   <= '0;
      r_err_cnt   <= '0;
      r_clean_cnt <= '0;
    end else if (i_rx_en) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_hit) begin
            r_cand_off  <= w_hit_off;
            r_align_off <= w_hit_off;
            r_ok_cnt    <= OK_W'(1);
            r_gap_cnt   <= '0;
            if (LOCK_CNT == 1) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state  <= ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (w_hit && (w_hit_off == r_cand_off)) begin
            r_gap_cnt <= '0;
            r_ok_cnt  <= (r_ok_cnt == c_OK_MAX) ? r_ok_cnt : r_ok_cnt + 1'b1;
            if (r_ok_cnt >= c_OK_MAX - 1'b1) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_align_off <= r_cand_off;
            end
          end else if (w_hit) begin
            // a comma elsewhere restarts qualification on the new offset
            r_cand_off  <= w_hit_off;
            r_align_off <= w_hit_off;
            r_ok_cnt    <= OK_W'(1);
            r_gap_cnt   <= '0;
          end else begin
            r_gap_cnt <= (r_gap_cnt == c_GAP_MAX) ? r_gap_cnt : r_gap_cnt + 1'b1;
            if (r_gap_cnt >= c_GAP_MAX - 1'b1) begin
              r_state     <= ST_SEARCH;
              r_ok_cnt    <= '0;
              r_gap_cnt   <= '0;
              r_err_cnt   <= '0;
              r_clean_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_err_evt) begin
            r_clean_cnt <= '0;
            r_err_cnt   <= (r_err_cnt == c_ERR_MAX) ? r_err_cnt : r_err_cnt + 1'b1;
            if (w_drop) begin
              r_state     <= ST_SEARCH;
              r_locked    <= 1'b0;
              r_ok_cnt    <= '0;
              r_gap_cnt   <= '0;
              r_err_cnt   <= '0;
              r_clean_cnt <= '0;
            end
          end else if (r_clean_cnt >= c_CLR_MAX - 1'b1) begin
            // a full clean window forgives earlier errors
            r_err_cnt   <= '0;
            r_clean_cnt <= '0;
          end else begin
            r_clean_cnt <= r_clean_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYMLOCK_RELOCK_CNT_EN
  logic [7:0] r_relock_cnt;

  // Count lock losses, saturating; only the reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_relock_cnt <= '0;
    end else if (i_rx_en && w_drop && (r_relock_cnt != 8'hFF)) begin
      r_relock_cnt <= r_relock_cnt + 1'b1;
    end
  end

  assign o_relock_cnt = r_relock_cnt;
`endif

  assign o_data_out    = r_data_out;
  assign o_align_off   = r_align_off;
  assign o_rx_valid    = r_locked;
  assign o_comma_pulse = r_comma_pulse;
  assign o_locked      = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_symbol_lock_ctrl.sv
// ============================================================================
// Module      : tb_symbol_lock_ctrl
// Description : Self-checking bench for symbol_lock_ctrl: table-driven lock
//               sequence, directed corner sequences and randomized traffic
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_symbol_lock_ctrl;

  localparam int LOCK_CNT = 3;
  localparam int GAP_MAX  = 64;
  localparam int ERR_MAX  = 4;
  localparam int CLR_WIN  = 16;
  localparam logic [9:0] K28P = 10'b0011111010;
  localparam logic [9:0] K28N = 10'b1100000101;

  localparam int HUNT = 0;
  localparam int CONF = 1;
  localparam int LOCK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_rx_en = 1'b0;
  logic [9:0] i_data_in = '0;
  logic       i_code_err = 1'b0;
  logic [9:0] o_data_out;
  logic [3:0] o_align_off;
  logic       o_rx_valid;
  logic       o_comma_pulse;
  logic       o_locked;
`ifdef SYMLOCK_RELOCK_CNT_EN
  logic [7:0] o_relock_cnt;
`endif

  symbol_lock_ctrl #(
    .LOCK_CNT(LOCK_CNT), .GAP_MAX(GAP_MAX), .ERR_MAX(ERR_MAX), .CLR_WIN(CLR_WIN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rx_en       (i_rx_en),
    .i_data_in     (i_data_in),
    .i_code_err    (i_code_err),
    .o_data_out    (o_data_out),
    .o_align_off   (o_align_off),
    .o_rx_valid    (o_rx_valid),
    .o_comma_pulse (o_comma_pulse),
    .o_locked      (o_locked)
`ifdef SYMLOCK_RELOCK_CNT_EN
    ,
    .o_relock_cnt  (o_relock_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  logic [9:0] m_prev, m_dout;
  bit         m_pulse, m_lock;
  int         m_mode, m_align, m_cand, m_ok, m_gap, m_err, m_clean, m_relock;

  function automatic int find_comma(logic [19:0] w);
    logic [19:0] s;
    for (int k = 0; k < 10; k++) begin
      s = w >> (10 - k);
      if (s[9:0] == K28P || s[9:0] == K28N) return k;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_prev = '0; m_dout = '0; m_pulse = 0; m_lock = 0;
    m_mode = HUNT; m_align = 0; m_cand = 0;
    m_ok = 0; m_gap = 0; m_err = 0; m_clean = 0; m_relock = 0;
  endtask

  task automatic m_hunt();
    m_mode = HUNT; m_ok = 0; m_gap = 0; m_err = 0; m_clean = 0;
  endtask

  task automatic m_step(bit en, logic [9:0] d, bit err);
    logic [19:0] win, sh;
    int h;
    bit ev;
    if (!en) return;
    win = {m_prev, d};
    h = find_comma(win);
    sh = win >> (10 - m_align);
    m_dout  = sh[9:0];
    m_pulse = (m_mode == LOCK) && (h == m_align);
    case (m_mode)
      HUNT: if (h >= 0) begin
        m_cand = h; m_align = h; m_ok = 1; m_gap = 0;
        m_mode = (LOCK_CNT == 1) ? LOCK : CONF;
      end
      CONF: if (h >= 0 && h == m_cand) begin
        m_ok++; m_gap = 0;
        if (m_ok >= LOCK_CNT) begin m_mode = LOCK; m_align = m_cand; end
      end else if (h >= 0) begin
        m_cand = h; m_align = h; m_ok = 1; m_gap = 0;
      end else begin
        m_gap++;
        if (m_gap >= GAP_MAX) m_hunt();
      end
      default: begin
        ev = err || (h >= 0 && h != m_align);
        if (ev) begin
          m_err++; m_clean = 0;
          if (m_err >= ERR_MAX) begin
            m_hunt();
            if (m_relock < 255) m_relock++;
          end
        end else begin
          m_clean++;
          if (m_clean >= CLR_WIN) begin m_err = 0; m_clean = 0; end
        end
      end
    endcase
    m_lock = (m_mode == LOCK);
    m_prev = d;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
`ifdef SYMLOCK_RELOCK_CNT_EN
    check("model", {7'd0, o_relock_cnt, o_data_out, o_align_off, o_rx_valid, o_comma_pulse, o_locked},
          {7'd0, 8'(m_relock), m_dout, 4'(m_align), m_lock, m_pulse, m_lock});
`else
    check("model", {15'd0, o_data_out, o_align_off, o_rx_valid, o_comma_pulse, o_locked},
          {15'd0, m_dout, 4'(m_align), m_lock, m_pulse, m_lock});
`endif
  endtask

  task automatic cyc(bit en, logic [9:0] d, bit err);
    i_rx_en = en; i_data_in = d; i_code_err = err;
    @(posedge clk);
    m_step(en, d, err);
    #1;
    cmp_model();
  endtask

  // asynchronous reset asserted mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    i_rx_en = 0; i_data_in = '0; i_code_err = 0;
    rst_n = 1'b0;
    #2;
`ifdef SYMLOCK_RELOCK_CNT_EN
    check("async_reset", {o_relock_cnt, o_data_out, o_align_off, o_rx_valid, o_comma_pulse, o_locked}, 0);
`else
    check("async_reset", {o_data_out, o_align_off, o_rx_valid, o_comma_pulse, o_locked}, 0);
`endif
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [9:0] cw_a(int k);
    logic [19:0] w;
    w = {10'd0, K28P} << (10 - k);
    return w[19:10];
  endfunction

  function automatic logic [9:0] cw_b(int k);
    logic [19:0] w;
    w = {10'd0, K28P} << (10 - k);
    return w[9:0];
  endfunction

  task automatic send_comma(int k, bit err_b);
    cyc(1, cw_a(k), 0);
    cyc(1, cw_b(k), err_b);
  endtask

  task automatic lock_at(int k);
    for (int i = 0; i < LOCK_CNT; i++) begin
      if (i > 0) begin cyc(1, '0, 0); cyc(1, '0, 0); end
      send_comma(k, 0);
    end
  endtask

  task automatic idle(int n, bit err);
    for (int i = 0; i < n; i++) cyc(1, '0, err);
  endtask

  typedef struct {
    bit         en;
    logic [9:0] d;
    bit         err;
    bit         exp_lock;
    logic [3:0] exp_align;
    bit         exp_pulse;
    bit         chk_dout;
    logic [9:0] exp_dout;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int cur_off, pend_valid;
    logic [9:0] pend;
    bit en, er;
    int r;

    #1;
    do_reset();

    // ---- table: commas at offset 3 every 4 words ----
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        tbl[4*c+j].en        = 1;
        tbl[4*c+j].d         = (j == 0) ? cw_a(3) : (j == 1) ? cw_b(3) : 10'd0;
        tbl[4*c+j].err       = 0;
        tbl[4*c+j].exp_lock  = (c == 2 && j >= 1) || (c == 3);
        tbl[4*c+j].exp_align = (c == 0 && j == 0) ? 4'd0 : 4'd3;
        tbl[4*c+j].exp_pulse = (c == 3 && j == 1);
        tbl[4*c+j].chk_dout  = (c >= 1 && j == 1);
        tbl[4*c+j].exp_dout  = K28P;
      end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].en, tbl[i].d, tbl[i].err);
      check("tbl_locked", o_locked, tbl[i].exp_lock);
      check("tbl_rx_valid", o_rx_valid, tbl[i].exp_lock);
      check("tbl_align", o_align_off, tbl[i].exp_align);
      check("tbl_pulse", o_comma_pulse, tbl[i].exp_pulse);
      if (tbl[i].chk_dout) check("tbl_dout", o_data_out, tbl[i].exp_dout);
    end

    // ---- offsets 3,3,7,7,7: qualification restarts on offset 7 ----
    do_reset();
    send_comma(3, 0); idle(2, 0);
    send_comma(3, 0); idle(2, 0);
    send_comma(7, 0); idle(2, 0);
    check("restart_align", o_align_off, 7);
    send_comma(7, 0); idle(2, 0);
    check("restart_not_locked", o_locked, 0);
    send_comma(7, 0);
    check("restart_locked", o_locked, 1);
    check("restart_lock_off", o_align_off, 7);

    // ---- VERIFY gap timeout ----
    do_reset();
    send_comma(5, 0);
    idle(GAP_MAX, 0);
    check("gap_locked", o_locked, 0);
    send_comma(5, 0); idle(2, 0); send_comma(5, 0);
    check("gap_ok_cleared", o_locked, 0);
    idle(2, 0); send_comma(5, 0);
    check("gap_relock", o_locked, 1);
    // just under the gap limit qualification continues
    do_reset();
    send_comma(5, 0);
    idle(GAP_MAX - 2, 0);
    send_comma(5, 0); idle(2, 0); send_comma(5, 0);
    check("gap_just_under", o_locked, 1);

    // ---- error handling in LOCKED ----
    do_reset();
    lock_at(3);
    idle(ERR_MAX - 1, 1);
    check("err_below_max", o_locked, 1);
    idle(1, 1);
    check("err_drop_locked", o_locked, 0);
    check("err_drop_valid", o_rx_valid, 0);
    lock_at(3);
    idle(ERR_MAX - 1, 1);
    idle(CLR_WIN, 0);
    idle(ERR_MAX - 1, 1);
    check("clean_window_clears", o_locked, 1);
    idle(1, 1);
    check("clean_then_drop", o_locked, 0);
    lock_at(3);
    idle(ERR_MAX - 1, 1);
    idle(CLR_WIN - 1, 0);
    idle(1, 1);
    check("clean_short_drop", o_locked, 0);

    // ---- simultaneous error sources count once; stalls hold ----
    do_reset();
    lock_at(3);
    send_comma(7, 1);
    idle(ERR_MAX - 2, 1);
    check("simul_once", o_locked, 1);
    for (int i = 0; i < 5; i++) cyc(0, 10'($urandom), 1);
    check("stall_hold", o_locked, 1);
    idle(1, 1);
    check("simul_drop", o_locked, 0);

    // ---- reset mid-VERIFY and mid-LOCKED, lock-loss counting ----
    do_reset();
    send_comma(3, 0);
    do_reset();
    lock_at(3); idle(ERR_MAX, 1);
    lock_at(3); idle(ERR_MAX, 1);
`ifdef SYMLOCK_RELOCK_CNT_EN
    check("relock_two", o_relock_cnt, 2);
`endif
    lock_at(3); idle(2, 0);
    send_comma(3, 0);
    check("pulse_before_reset", o_comma_pulse, 1);
    do_reset();

    // ---- randomized traffic ----
    cur_off = $urandom_range(0, 9);
    pend_valid = 0;
    pend = '0;
    for (int n = 0; n < 4000; n++) begin
      en = ($urandom_range(0, 99) < 90);
      er = ($urandom_range(0, 99) < 4);
      if (!en) begin
        cyc(0, 10'($urandom), er);
      end else if (pend_valid != 0) begin
        cyc(1, pend, er);
        pend_valid = 0;
      end else begin
        r = $urandom_range(0, 99);
        if ($urandom_range(0, 99) < 1) cur_off = $urandom_range(0, 9);
        if (r < 20) begin
          int k;
          k = ($urandom_range(0, 9) < 8) ? cur_off : $urandom_range(0, 9);
          cyc(1, cw_a(k), er);
          pend = cw_b(k);
          pend_valid = 1;
        end else if (r < 30) begin
          cyc(1, 10'($urandom), er);
        end else begin
          cyc(1, '0, er);
        end
      end
      if (n == 2000) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
